mips_cpu_avalon_bus: RTL and testbench

- Multicycle 32-bit MIPS I subset CPU with a single Avalon-MM master port, shared by instruction fetch and data access.
- Boots from 0xBFC00000 and runs until it jumps to address 0, then halts and drops `active`.
- `register_v0` exposes $2 so system benches can check results.

---
 rtl/mips_cpu_avalon_bus.sv | 249 ++++++++++++++++++++++++
 tb/tb_mips_cpu_avalon_bus.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_avalon_bus.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_avalon_bus
// Purpose  : Multicycle 32-bit MIPS I subset CPU. A single Avalon-MM master
//            port is shared by instruction fetch and load/store traffic. The
//            core boots from RESET_VECTOR and halts once the next PC to be
//            fetched is 0x00000000.
// Ports    : clk, reset         - clock, asynchronous active-high reset
//            active             - high while the core is executing
//            register_v0        - live value of GPR $2
//            address/read/write - Avalon-MM master command signals
//            writedata          - store data
//            byteenable         - constant 4'b1111 (word accesses only)
//            readdata           - read data, valid when read=1, waitrequest=0
//            waitrequest        - slave stall, holds the current transfer
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_avalon_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_MEM    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        active_q, active_d;
    logic        pending_q, pending_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] target_q, target_d;
    logic [31:0] addr_q;
    logic [31:0] regs_q [32];

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx, shamt;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, mem_addr;
    logic        is_lw, is_sw;

    assign opcode   = ir_q[31:26];
    assign rs_idx   = ir_q[25:21];
    assign rt_idx   = ir_q[20:16];
    assign rd_idx   = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign rs_val   = regs_q[rs_idx];
    assign rt_val   = regs_q[rt_idx];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    // pc_q holds the address of the instruction in IR during EXEC
    assign pc_plus4 = pc_q + 32'd4;
    assign mem_addr = rs_val + imm_sext;
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);

    // ------------------------------------------------------------------
    // Execute: ALU result, write-back target and control transfer
    // ------------------------------------------------------------------
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val;
    logic        take;
    logic [31:0] tgt;

    always_comb begin
        wb_en  = 1'b0;
        wb_idx = rt_idx;
        wb_val = 32'h0;
        take   = 1'b0;
        tgt    = 32'h0;
        case (opcode)
            6'h00: begin
                wb_idx = rd_idx;
                wb_en  = 1'b1;
                case (funct)
                    6'h21: wb_val = rs_val + rt_val;
                    6'h23: wb_val = rs_val - rt_val;
                    6'h24: wb_val = rs_val & rt_val;
                    6'h25: wb_val = rs_val | rt_val;
                    6'h26: wb_val = rs_val ^ rt_val;
                    6'h2A: wb_val = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: wb_val = {31'h0, rs_val < rt_val};
                    6'h00: wb_val = rt_val << shamt;
                    6'h02: wb_val = rt_val >> shamt;
                    6'h03: wb_val = $unsigned($signed(rt_val) >>> shamt);
                    6'h08: begin
                        wb_en = 1'b0;
                        take  = 1'b1;
                        tgt   = rs_val;
                    end
                    6'h09: begin
                        take   = 1'b1;
                        tgt    = rs_val;
                        wb_val = pc_q + 32'd8;
                    end
                    default: wb_en = 1'b0;
                endcase
            end
            6'h09: begin wb_en = 1'b1; wb_val = rs_val + imm_sext; end
            6'h0C: begin wb_en = 1'b1; wb_val = rs_val & imm_zext; end
            6'h0D: begin wb_en = 1'b1; wb_val = rs_val | imm_zext; end
            6'h0E: begin wb_en = 1'b1; wb_val = rs_val ^ imm_zext; end
            6'h0F: begin wb_en = 1'b1; wb_val = {ir_q[15:0], 16'h0000}; end
            6'h0A: begin wb_en = 1'b1; wb_val = {31'h0, $signed(rs_val) < $signed(imm_sext)}; end
            6'h0B: begin wb_en = 1'b1; wb_val = {31'h0, rs_val < imm_sext}; end
            6'h04: begin take = (rs_val == rt_val); tgt = pc_plus4 + (imm_sext << 2); end
            6'h05: begin take = (rs_val != rt_val); tgt = pc_plus4 + (imm_sext << 2); end
            6'h02: begin take = 1'b1; tgt = {pc_plus4[31:28], ir_q[25:0], 2'b00}; end
            6'h03: begin
                take   = 1'b1;
                tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                wb_en  = 1'b1;
                wb_idx = 5'd31;
                wb_val = pc_q + 32'd8;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file write port, shared by EXEC write-back and LW return
    // ------------------------------------------------------------------
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wb_idx;
        rf_wdata = wb_val;
        if (state_q == S_EXEC) begin
            rf_we = wb_en;
        end else if (state_q == S_MEM && is_lw && !waitrequest) begin
            rf_we    = 1'b1;
            rf_waddr = rt_idx;
            rf_wdata = readdata;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM next-state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        target_d  = target_q;
        read      = 1'b0;
        write     = 1'b0;
        address   = addr_q;
        writedata = 32'h0;
        case (state_q)
            S_FETCH: begin
                // active_q is low only on the first cycle after reset
                if (active_q) begin
                    read    = 1'b1;
                    address = pc_q & ~32'h3;
                    if (!waitrequest) begin
                        ir_d    = readdata;
                        state_d = S_EXEC;
                    end
                end else begin
                    active_d = 1'b1;
                end
            end
            S_EXEC: begin
                // A pending target belongs to the branch before this
                // instruction, so this instruction was its delay slot.
                pc_d      = pending_q ? target_q : pc_plus4;
                pending_d = take;
                target_d  = tgt;
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (pc_d == 32'h0) begin
                    state_d  = S_HALTED;
                    active_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                address   = mem_addr & ~32'h3;
                read      = is_lw;
                write     = is_sw;
                writedata = is_sw ? rt_val : 32'h0;
                if (!waitrequest) begin
                    if (pc_q == 32'h0) begin
                        state_d  = S_HALTED;
                        active_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            pc_q      <= RESET_VECTOR;
            ir_q      <= 32'h0;
            target_q  <= 32'h0;
            addr_q    <= RESET_VECTOR;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            target_q  <= target_d;
            addr_q    <= address;
            // $0 is never written, so it keeps its reset value of zero
            if (rf_we && rf_waddr != 5'd0) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    assign active      = active_q;
    assign register_v0 = regs_q[2];
    assign byteenable  = 4'b1111;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_avalon_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_avalon_bus
// Purpose  : Self-checking bench for mips_cpu_avalon_bus. A behavioural
//            Avalon slave serves a boot ROM and a data RAM; expected fetch
//            addresses and store transactions are queued per program and
//            matched as the core issues them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_avalon_bus;

    localparam logic [31:0] ROM_BASE = 32'hBFC00000;
    localparam logic [31:0] RAM_BASE = 32'h10000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'h0;

    mips_cpu_avalon_bus #(.RESET_VECTOR(ROM_BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model and scoreboard queues
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] rom  [64];
    logic [31:0] dram [16];
    logic [31:0] exp_fetch [$];
    wr_t         exp_wr [$];

    logic [31:0] st_addr [2];
    bit          st_en   [2];
    bit          st_used [2];
    int          st_len = 3;
    int          stall_left = 0;
    logic [31:0] stall_a = 32'h0;

    function automatic bit in_rom(input logic [31:0] a);
        return (a >= ROM_BASE) && (a < ROM_BASE + 32'd256);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] off;
        if (in_rom(a)) begin
            off = a - ROM_BASE;
            return rom[off[7:2]];
        end
        off = a - RAM_BASE;
        return dram[off[5:2]];
    endfunction

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    // Avalon slave: decide waitrequest for the coming edge, serve data and
    // score fetches / stores that complete on that edge.
    always @(negedge clk) begin
        logic [31:0] off;
        wr_t         w;
        if (reset) begin
            waitrequest = 1'b0;
            stall_left  = 0;
        end else begin
            if (stall_left == 0 && read) begin
                for (int k = 0; k < 2; k++) begin
                    if (st_en[k] && !st_used[k] && address == st_addr[k] && stall_left == 0) begin
                        st_used[k] = 1'b1;
                        stall_left = st_len;
                        stall_a    = address;
                    end
                end
            end
            if (stall_left > 0) begin
                chk("stall_addr", address, stall_a);
                chk("stall_read", {31'h0, read}, 32'd1);
                waitrequest = 1'b1;
                readdata    = 32'hDEADBEEF;
                stall_left--;
            end else begin
                waitrequest = 1'b0;
                if (read || write) chk("rd_wr_excl", {31'h0, read & write}, 32'd0);
                if (read) begin
                    readdata = mem_rd(address);
                    if (in_rom(address)) begin
                        if (exp_fetch.size() == 0) chk("fetch_extra", address, 32'hFFFFFFFF);
                        else chk("fetch_addr", address, exp_fetch.pop_front());
                    end
                end
                if (write) begin
                    chk("byteenable", {28'h0, byteenable}, 32'hF);
                    if (exp_wr.size() == 0) begin
                        chk("write_extra", address, 32'hFFFFFFFF);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("write_addr", address, w.a);
                        chk("write_data", writedata, w.d);
                    end
                    off = address - RAM_BASE;
                    dram[off[5:2]] = writedata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Test helpers
    // ------------------------------------------------------------------
    task automatic clear_all();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        for (int i = 0; i < 16; i++) dram[i] = 32'h0;
        exp_fetch.delete();
        exp_wr.delete();
        st_en[0] = 1'b0; st_en[1] = 1'b0;
        st_used[0] = 1'b0; st_used[1] = 1'b0;
        st_len = 3;
    endtask

    task automatic push_fetch(input int first, input int last);
        for (int i = first; i <= last; i++) exp_fetch.push_back(ROM_BASE + 32'(i * 4));
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_read",   {31'h0, read},   32'd0);
        chk("rst_write",  {31'h0, write},  32'd0);
        chk("rst_active", {31'h0, active}, 32'd0);
        chk("rst_addr",   address,         ROM_BASE);
        chk("rst_wdata",  writedata,       32'h0);
        chk("rst_v0",     register_v0,     32'h0);
        reset = 1'b0;
    endtask

    task automatic wait_halt(output int cycles);
        bit seen = 1'b0;
        bit done = 1'b0;
        cycles = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (active) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk("halted", {31'h0, done}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_bus", {30'h0, read, write}, 32'd0);
        end
        chk("fetch_left", 32'(exp_fetch.size()), 32'd0);
        chk("write_left", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic run_prog(input string name, input logic [31:0] exp_v0, output int cycles);
        do_reset();
        @(negedge clk);
        chk("boot_read",   {31'h0, read},   32'd1);
        chk("boot_addr",   address,         ROM_BASE);
        chk("boot_active", {31'h0, active}, 32'd1);
        chk("boot_be",     {28'h0, byteenable}, 32'hF);
        wait_halt(cycles);
        chk(name, register_v0, exp_v0);
    endtask

    task automatic load_rw_prog();
        clear_all();
        rom[0] = ei(6'h0F, 5'd0, 5'd3, 16'h1000);
        rom[1] = ei(6'h0D, 5'd0, 5'd4, 16'hABCD);
        rom[2] = ei(6'h2B, 5'd3, 5'd4, 16'h0008);
        rom[3] = ei(6'h23, 5'd3, 5'd2, 16'h0008);
        rom[4] = er(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        rom[5] = 32'h0;
        push_fetch(0, 5);
        push_wr(32'h10000008, 32'h0000ABCD);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cyc_plain, cyc_stall, cyc;

        // Halt program: ADDIU $2,$0,5; JR $0; NOP
        clear_all();
        rom[0] = ei(6'h09, 5'd0, 5'd2, 16'h0005);
        rom[1] = er(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        push_fetch(0, 2);
        run_prog("v0_halt", 32'd5, cyc);

        // Store/load round trip, without and with wait states
        load_rw_prog();
        run_prog("v0_ldst", 32'h0000ABCD, cyc_plain);
        load_rw_prog();
        st_addr[0] = ROM_BASE + 32'd4; st_en[0] = 1'b1;
        st_addr[1] = 32'h10000008;     st_en[1] = 1'b1;
        run_prog("v0_ldst_stall", 32'h0000ABCD, cyc_stall);
        chk("stall_cycles", 32'(cyc_stall - cyc_plain), 32'd6);

        // Branch delay slot
        clear_all();
        rom[0] = ei(6'h04, 5'd0, 5'd0, 16'h0002);
        rom[1] = ei(6'h09, 5'd0, 5'd2, 16'h0001);
        rom[2] = ei(6'h09, 5'd2, 5'd2, 16'h000A);
        rom[3] = ei(6'h09, 5'd2, 5'd2, 16'h0064);
        rom[4] = er(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        push_fetch(0, 1);
        push_fetch(3, 5);
        run_prog("v0_branch", 32'd101, cyc);

        // ALU mix, JAL/BNE/BEQ/JALR, results stored to RAM
        clear_all();
        rom[0]  = ei(6'h09, 5'd0, 5'd5, 16'hFFF8);
        rom[1]  = ei(6'h0F, 5'd0, 5'd3, 16'h1000);
        rom[2]  = er(5'd0, 5'd5, 5'd6, 5'd1, 6'h03);
        rom[3]  = ei(6'h2B, 5'd3, 5'd6, 16'h0000);
        rom[4]  = er(5'd0, 5'd5, 5'd7, 5'd28, 6'h02);
        rom[5]  = er(5'd5, 5'd7, 5'd8, 5'd0, 6'h2A);
        rom[6]  = er(5'd5, 5'd7, 5'd9, 5'd0, 6'h2B);
        rom[7]  = er(5'd7, 5'd5, 5'd10, 5'd0, 6'h23);
        rom[8]  = ei(6'h0E, 5'd5, 5'd11, 16'hFFFF);
        rom[9]  = ei(6'h2B, 5'd3, 5'd7, 16'h0004);
        rom[10] = er(5'd8, 5'd10, 5'd12, 5'd0, 6'h21);
        rom[11] = ei(6'h2B, 5'd3, 5'd12, 16'h0008);
        rom[12] = ei(6'h2B, 5'd3, 5'd11, 16'h000C);
        rom[13] = ei(6'h0A, 5'd5, 5'd13, 16'hFFF9);
        rom[14] = ei(6'h0B, 5'd0, 5'd14, 16'hFFFF);
        rom[15] = er(5'd0, 5'd13, 5'd15, 5'd4, 6'h00);
        rom[16] = er(5'd15, 5'd14, 5'd15, 5'd0, 6'h25);
        rom[17] = er(5'd5, 5'd15, 5'd16, 5'd0, 6'h24);
        rom[18] = er(5'd16, 5'd13, 5'd16, 5'd0, 6'h26);
        rom[19] = ei(6'h2B, 5'd3, 5'd16, 16'h0010);
        rom[20] = ei(6'h0C, 5'd5, 5'd17, 16'hFF0F);
        rom[21] = ei(6'h2B, 5'd3, 5'd17, 16'h0014);
        rom[22] = {6'h03, 26'h3F00019};
        rom[23] = ei(6'h09, 5'd0, 5'd2, 16'h0007);
        rom[24] = ei(6'h09, 5'd0, 5'd2, 16'h0063);
        rom[25] = ei(6'h2B, 5'd3, 5'd31, 16'h0018);
        rom[26] = ei(6'h05, 5'd2, 5'd0, 16'h0002);
        rom[27] = ei(6'h09, 5'd2, 5'd2, 16'h0001);
        rom[28] = ei(6'h09, 5'd2, 5'd2, 16'h0032);
        rom[29] = ei(6'h04, 5'd2, 5'd0, 16'h0005);
        rom[30] = ei(6'h09, 5'd2, 5'd2, 16'h0002);
        rom[31] = er(5'd0, 5'd0, 5'd20, 5'd0, 6'h09);
        rom[32] = ei(6'h2B, 5'd3, 5'd20, 16'h001C);
        push_fetch(0, 23);
        push_fetch(25, 27);
        push_fetch(29, 32);
        push_wr(32'h10000000, 32'hFFFFFFFC);
        push_wr(32'h10000004, 32'h0000000F);
        push_wr(32'h10000008, 32'h00000018);
        push_wr(32'h1000000C, 32'hFFFF0007);
        push_wr(32'h10000010, 32'h00000011);
        push_wr(32'h10000014, 32'h0000FF08);
        push_wr(32'h10000018, 32'hBFC00060);
        push_wr(32'h1000001C, 32'hBFC00084);
        run_prog("v0_mix", 32'd10, cyc);

        // Reset asserted during a stalled fetch
        clear_all();
        rom[0] = ei(6'h09, 5'd0, 5'd2, 16'h0005);
        rom[1] = er(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        push_fetch(0, 2);
        st_addr[0] = ROM_BASE; st_en[0] = 1'b1; st_len = 10;
        do_reset();
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                #1;
                if (waitrequest && read) got = 1'b1;
            end
            chk("stall_seen", {31'h0, got}, 32'd1);
        end
        #1 reset = 1'b1;
        #1;
        chk("async_read",   {31'h0, read},   32'd0);
        chk("async_active", {31'h0, active}, 32'd0);
        chk("async_addr",   address,         ROM_BASE);
        st_en[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_halt(cyc);
        chk("v0_restart", register_v0, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
